dmem_responder: RTL and testbench

//   Data-memory responder for the single-cycle CPU's load/store port. Accepts one

---
 rtl/dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_dmem_responder.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable wait states, then a held response.
// Optional macro DMEM_BOUNDS_CHECK_EN flags out-of-range or misaligned accesses.
module dmem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam int         LANES     = DATA_W / 8;
    localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_err;
    logic                r_busy;

    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_be;

    logic [DATA_W-1:0]   r_mem [DEPTH_WORDS];

    logic                w_accept;
    logic                w_enter;
    logic                w_src_we;
    logic [ADDR_W-1:0]   w_src_addr;
    logic [DATA_W-1:0]   w_src_wdata;
    logic [3:0]          w_src_be;
    logic [IDX_W-1:0]    w_idx;
    logic                w_err;
    logic                w_mem_we;
    logic [DATA_W-1:0]   w_rdata_next;

    assign w_accept = (r_state == S_IDLE) && r_req_ready && req_valid;

    // With no wait states the RESP entry edge is the accept edge itself, so the
    // access is resolved from the live request rather than the capture registers.
    assign w_src_we    = ZERO_WAIT ? req_we    : r_we;
    assign w_src_addr  = ZERO_WAIT ? req_addr  : r_addr;
    assign w_src_wdata = ZERO_WAIT ? req_wdata : r_wdata;
    assign w_src_be    = ZERO_WAIT ? req_be    : r_be;

    assign w_enter = ZERO_WAIT ? w_accept : ((r_state == S_WAIT) && (r_cnt == 4'd0));
    assign w_idx   = w_src_addr[2 +: IDX_W];

`ifdef DMEM_BOUNDS_CHECK_EN
    assign w_err = (|w_src_addr[ADDR_W-1:IDX_W+2]) ||
                   ((w_src_addr[1:0] != 2'b00) && (|w_src_be));
`else
    assign w_err = 1'b0;
    logic w_unused_addr;
    assign w_unused_addr = ^{w_src_addr[1:0], w_src_addr[ADDR_W-1:IDX_W+2]};
`endif

    assign w_mem_we     = w_enter && w_src_we && !w_err;
    assign w_rdata_next = (w_src_we || w_err) ? '0 : r_mem[w_idx];

    // NOTE: the RAM array is deliberately left out of reset; clearing it would
    // turn the storage into a huge register file instead of an inferred RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_src_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_src_wdata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: every state register uses non-blocking assignment, so the later
    // req_ready <= 0 on an accept cleanly overrides the default req_ready <= 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_be        <= req_be;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (ZERO_WAIT) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rdata_next;
                            r_rsp_err   <= w_err;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_enter) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rdata_next;
                        r_rsp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// against a word-array reference model (honours DMEM_BOUNDS_CHECK_EN when defined).
module tb_dmem_responder;

    localparam int WS    = 2;
    localparam int DEPTH = 256;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int checks;
    int errors;

    logic [31:0] model_mem [DEPTH];

    dmem_responder #(
        .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: word index is the byte address divided by four, modulo the depth.
    function automatic void model_access(input logic we, input logic [31:0] addr,
                                         input logic [31:0] wdata, input logic [3:0] be,
                                         output logic [31:0] exp_rdata, output logic exp_err);
        int idx;
        idx = int'((addr / 4) % DEPTH);
        exp_err = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
        if (addr >= 32'(DEPTH * 4) || ((addr % 4) != 0 && be != 4'd0)) exp_err = 1'b1;
`endif
        exp_rdata = '0;
        if (exp_err) return;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            exp_rdata = model_mem[idx];
        end
    endfunction

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold,
                       output logic [31:0] rdata, output logic err, output int lat, output bit ok);
        int n;
        ok = 1'b0; rdata = '0; err = 1'b0; lat = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        rsp_ready = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (rsp_valid !== 1'b1) return;
        repeat (hold) @(negedge clk);
        rdata = rsp_rdata;
        err   = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        ok = (rsp_valid === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        #100;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, busy, rsp_rdata} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b busy=%b rdata=%h, want all 0",
                     req_ready, rsp_valid, rsp_err, busy, rsp_rdata);
        end
        #50;
        rst = 1'b1;
        #2;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early: got %b want 0 before first edge", req_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_after_edge: got rdy=%b busy=%b vld=%b want 1 0 0",
                     req_ready, busy, rsp_valid);
        end
    endtask

    task automatic test_preload();
        logic [31:0] rd, er_d, d;
        logic        er, ee;
        int          lat;
        bit          ok;
        for (int w = 0; w < 32; w++) begin
            d = $urandom;
            model_access(1'b1, 32'(w * 4), d, 4'hF, er_d, ee);
            txn(1'b1, 32'(w * 4), d, 4'hF, 0, rd, er, lat, ok);
            checks++;
            if (!ok || rd !== 32'd0 || er !== 1'b0) begin
                errors++;
                $display("FAIL preload_w%0d: got ok=%0d rdata=%h err=%b want ok=1 rdata=0 err=0",
                         w, ok, rd, er);
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, xd;
        logic        er, xe;
        int          lat;
        bit          ok;
        model_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, xd, xe);
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (!ok || lat != WS + 1) begin
            errors++;
            $display("FAIL store_latency: got ok=%0d lat=%0d want ok=1 lat=%0d", ok, lat, WS + 1);
        end
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            errors++;
            $display("FAIL store_rsp: got rdata=%h err=%b want 0 0", rd, er);
        end
        txn(1'b0, 32'h10, 32'h0, 4'h0, 1, rd, er, lat, ok);
        checks++;
        if (!ok || lat != WS + 1 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL load_after_store: got ok=%0d lat=%0d rdata=%h err=%b want 1 %0d deadbeef 0",
                     ok, lat, rd, er, WS + 1);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, xd;
        logic        er, xe;
        int          lat;
        bit          ok;
        model_access(1'b1, 32'h10, 32'h0000AA00, 4'b0010, xd, xe);
        txn(1'b1, 32'h10, 32'h0000AA00, 4'b0010, 0, rd, er, lat, ok);
        txn(1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (!ok || rd !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL byte_lane1: got ok=%0d rdata=%h want deadaaef", ok, rd);
        end
        model_access(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, xd, xe);
        txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat, ok);
        checks++;
        if (!ok || lat != WS + 1 || er !== 1'b0) begin
            errors++;
            $display("FAIL be_zero_rsp: got ok=%0d lat=%0d err=%b want 1 %0d 0", ok, lat, er, WS + 1);
        end
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, ok);
        checks++;
        if (!ok || rd !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL be_zero_unchanged: got rdata=%h want deadaaef", rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] xd, rd, dd;
        logic        xe, er, de;
        int          n, lat;
        bit          ok;
        model_access(1'b0, 32'h14, 32'h0, 4'hF, xd, xe);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h14; req_be = 4'hF; rsp_ready = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        // a competing store is presented while the response is stalled
        req_we = 1'b1; req_addr = 32'h24; req_wdata = 32'h55555555; req_be = 4'hF;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== xd || rsp_err !== xe || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_c%0d: got vld=%b rdata=%h err=%b rdy=%b want 1 %h %b 0",
                         c, rsp_valid, rsp_rdata, rsp_err, req_ready, xd, xe);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignored_req_idle: got busy=%b vld=%b want 0 0", busy, rsp_valid);
        end
        model_access(1'b0, 32'h24, 32'h0, 4'h0, dd, de);
        txn(1'b0, 32'h24, 32'h0, 4'h0, 0, rd, er, lat, ok);
        checks++;
        if (!ok || rd !== dd) begin
            errors++;
            $display("FAIL ignored_req_ram: got rdata=%h want %h", rd, dd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] xd, rd;
        logic        xe, er;
        int          n, lat;
        bit          ok, seen;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h11111111; req_be = 4'hF;
        rsp_ready = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: got busy=%b vld=%b rdy=%b want 0 0 0", busy, rsp_valid, req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        rsp_ready = 1'b0;
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_reset_no_rsp: got a response want none");
        end
        model_access(1'b0, 32'h20, 32'h0, 4'h0, xd, xe);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, ok);
        checks++;
        if (!ok || rd !== xd) begin
            errors++;
            $display("FAIL mid_reset_ram: got rdata=%h want %h", rd, xd);
        end
    endtask

    task automatic test_bounds();
        logic [31:0] xd, rd;
        logic        xe, er;
        int          lat;
        bit          ok;
        model_access(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, xd, xe);
        txn(1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (!ok || lat != WS + 1 || er !== xe || rd !== 32'd0) begin
            errors++;
            $display("FAIL oob_store: got ok=%0d lat=%0d err=%b rdata=%h want 1 %0d %b 0",
                     ok, lat, er, rd, WS + 1, xe);
        end
        model_access(1'b0, 32'h0, 32'h0, 4'hF, xd, xe);
        txn(1'b0, 32'h0, 32'h0, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (!ok || rd !== xd || er !== xe) begin
            errors++;
            $display("FAIL oob_load_w0: got rdata=%h err=%b want %h %b", rd, er, xd, xe);
        end
        model_access(1'b1, 32'h11, 32'h12345678, 4'hF, xd, xe);
        txn(1'b1, 32'h11, 32'h12345678, 4'hF, 0, rd, er, lat, ok);
        checks++;
        if (!ok || er !== xe) begin
            errors++;
            $display("FAIL misaligned_store: got err=%b want %b", er, xe);
        end
        model_access(1'b0, 32'h13, 32'h0, 4'h0, xd, xe);
        txn(1'b0, 32'h13, 32'h0, 4'h0, 0, rd, er, lat, ok);
        checks++;
        if (!ok || rd !== xd || er !== xe) begin
            errors++;
            $display("FAIL misaligned_load_be0: got rdata=%h err=%b want %h %b", rd, er, xd, xe);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xd;
        logic        xe;
        int          acc[$];
        int          n;
        model_access(1'b0, 32'h10, 32'h0, 4'hF, xd, xe);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; rsp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (req_ready === 1'b1) acc.push_back(c);
            if (rsp_valid === 1'b1) begin
                checks++;
                if (rsp_rdata !== xd || rsp_err !== xe) begin
                    errors++;
                    $display("FAIL b2b_data_c%0d: got %h/%b want %h/%b", c, rsp_rdata, rsp_err, xd, xe);
                end
            end
        end
        req_valid = 1'b0;
        n = 0;
        while ((busy !== 1'b0 || rsp_valid !== 1'b0) && n < 20) begin @(negedge clk); n++; end
        rsp_ready = 1'b0;
        checks++;
        if (acc.size() < 3) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d accepts want at least 3", acc.size());
        end else if (acc[1] - acc[0] != WS + 2 || acc[2] - acc[1] != WS + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d,%0d want %0d", acc[1] - acc[0], acc[2] - acc[1], WS + 2);
        end
    endtask

    task automatic test_random();
        logic        we, er, xe;
        logic [31:0] addr, d, rd, xd;
        logic [3:0]  be;
        int          r, lat, hold;
        bit          ok;
        for (int t = 0; t < 40; t++) begin
            we   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 31) * 4);
            r    = $urandom_range(0, 9);
            if (r == 0) addr = addr | (32'd1 << $urandom_range(10, 31));
            if (r == 1) addr = addr | 32'($urandom_range(1, 3));
            d    = $urandom;
            be   = 4'($urandom_range(0, 15));
            hold = $urandom_range(0, 3);
            model_access(we, addr, d, be, xd, xe);
            txn(we, addr, d, be, hold, rd, er, lat, ok);
            checks++;
            if (!ok || lat != WS + 1) begin
                errors++;
                $display("FAIL rand%0d_timing: got ok=%0d lat=%0d want 1 %0d", t, ok, lat, WS + 1);
            end
            checks++;
            if (rd !== xd || er !== xe) begin
                errors++;
                $display("FAIL rand%0d_data: we=%b addr=%h be=%h got %h/%b want %h/%b",
                         t, we, addr, be, rd, er, xd, xe);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = 4'h0;
        rsp_ready = 1'b0;
        test_reset();
        test_preload();
        test_store_load();
        test_byte_lanes();
        test_backpressure();
        test_reset_mid();
        test_bounds();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
